// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, parity modes,
// default oversampling ratio and a constant-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_NONE = 2;

  localparam int UART_OVERSAMPLE = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: received byte, valid/ack
// handshake, error pulses and busy indication.
interface uart_rx_if #(
  parameter int FRAME_BITS = 8
);
  logic [FRAME_BITS-1:0] data;
  logic                  data_valid;
  logic                  data_ack;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun_err;
  logic                  rx_busy;

  modport master (
    output data, data_valid, parity_err, frame_err, overrun_err, rx_busy,
    input  data_ack
  );

  modport slave (
    input  data, data_valid, parity_err, frame_err, overrun_err, rx_busy,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin followed by a three-tap
// majority vote over the current and two previous synchronized samples.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_maj
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_tap;

  // Idle line is high, so every stage resets to 1 to avoid a false start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_tap  <= 2'b11;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_tap  <= {r_tap[0], r_sync};
    end
  end

  assign o_rx_s = r_sync;
  assign o_maj  = (r_sync & r_tap[0]) | (r_sync & r_tap[1]) | (r_tap[0] & r_tap[1]);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: reframes start/data/parity/stop bits into bytes,
// hands them over with valid/ack and pulses parity, framing and overrun errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int PARITY_BIT = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  uart_rx_if.master bus
);

  localparam int CW  = clog2(OVERSAMPLE);
  localparam int BW  = clog2(FRAME_BITS) + 1;
  localparam int MID = OVERSAMPLE / 2 - 1;

  localparam logic [CW-1:0] C_SAMPLE = CW'(MID + 1);
  localparam logic [CW-1:0] C_END    = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] S_LAST   = BW'(STOP_BITS - 1);

  uart_state_t           r_state, w_state_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [BW-1:0]         r_bit, w_bit_next;
  logic [FRAME_BITS-1:0] r_shift, r_data, w_hit;
  logic                  r_rx_prev, r_parity_bad, r_frame_bad;
  logic                  r_valid, r_perr, r_ferr, r_oerr;
  logic                  w_rx_s, w_maj, w_fall, w_at_sample, w_at_end, w_par_exp;
  logic                  w_start, w_take_data, w_take_par, w_take_stop, w_done;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_maj  (w_maj)
  );

  assign w_fall      = r_rx_prev & ~w_rx_s;
  assign w_at_sample = (r_cnt == C_SAMPLE);
  assign w_at_end    = (r_cnt == C_END);
  assign w_par_exp   = (^r_shift) ^ (PARITY_BIT == PAR_ODD);

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_BITS; gi++) begin : g_hit
      assign w_hit[gi] = (r_bit == BW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_rx_prev <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit     <= w_bit_next;
      r_rx_prev <= w_rx_s;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_start      = 1'b0;
    w_take_data  = 1'b0;
    w_take_par   = 1'b0;
    w_take_stop  = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        w_bit_next = '0;
        if (w_fall) begin
          w_state_next = START;
          w_start      = 1'b1;
        end
      end
      START: begin
        if (w_at_sample && w_maj) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (w_at_end) begin
          w_state_next = DATA;
          w_cnt_next   = '0;
        end
      end
      DATA: begin
        w_take_data = w_at_sample;
        if (w_at_end) begin
          w_cnt_next = '0;
          w_bit_next = r_bit + 1'b1;
          if (r_bit == B_LAST) begin
            w_bit_next   = '0;
            w_state_next = (PARITY_BIT == PAR_NONE) ? STOP : PARITY;
          end
        end
      end
      PARITY: begin
        w_take_par = w_at_sample;
        if (w_at_end) begin
          w_cnt_next   = '0;
          w_state_next = STOP;
        end
      end
      STOP: begin
        // Leave at the final stop sample so a back-to-back start edge is caught.
        if (w_at_sample) begin
          w_take_stop = 1'b1;
          if (r_bit == S_LAST) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_bit_next   = '0;
          end
        end else if (w_at_end) begin
          w_cnt_next = '0;
          w_bit_next = r_bit + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_bit_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_data       <= '0;
      r_parity_bad <= 1'b0;
      r_frame_bad  <= 1'b0;
      r_valid      <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_oerr       <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
      if (w_start) begin
        r_parity_bad <= 1'b0;
        r_frame_bad  <= 1'b0;
      end
      for (int i = 0; i < FRAME_BITS; i++) begin
        if (w_take_data && w_hit[i]) r_shift[i] <= w_maj;
      end
      if (w_take_par) r_parity_bad <= (w_maj != w_par_exp);
      if (w_take_stop && !w_maj) r_frame_bad <= 1'b1;
      if (r_valid && bus.data_ack) r_valid <= 1'b0;
      // A completing frame wins over the ack; overrun only if the old byte was unclaimed.
      if (w_done) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_perr  <= r_parity_bad;
        r_ferr  <= r_frame_bad | ~w_maj;
        r_oerr  <= r_valid & ~bus.data_ack;
      end
    end
  end

  assign bus.data        = r_data;
  assign bus.data_valid  = r_valid;
  assign bus.parity_err  = r_perr;
  assign bus.frame_err   = r_ferr;
  assign bus.overrun_err = r_oerr;
  assign bus.rx_busy     = (r_state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver; the receive-side counterpart of the team's UART transmitter.
- Samples the serial line on the shared oversampled UART clock and reframes start / data / parity / stop bits into parallel bytes.
- Delivers each byte to the consumer through a valid/ack handshake and flags parity, framing and overrun errors.
- Sits between the board RX pin and the game/control logic.

Parameters:
- FRAME_BITS, 8, data bits per frame (7 or 8); received LSB first.
- PARITY_BIT, 2, 0 = even (parity bit equals XOR of data), 1 = odd, 2 = no parity bit.
- STOP_BITS, 1, stop bits expected (1 or 2).
- OVERSAMPLE, 16, clk cycles per bit; must equal the transmitter's retention duration + 1.

Ports:
- clk  in  1  UART oversampling clock, shared with the transmitter.
- rst_n  in  1  synchronous reset, active low.
- rx  in  1  serial line, asynchronous, idle high.
- data  out  FRAME_BITS  received byte; stable while data_valid = 1.
- data_valid  out  1  byte available; held until acknowledged.
- data_ack  in  1  consumer accepts the byte.
- parity_err  out  1  one-cycle pulse alongside the frame-complete event.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- overrun_err  out  1  one-cycle pulse when a frame completes while data_valid is still 1.
- rx_busy  out  1  high from start-bit detect until return to IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is synchronous, active low.
- Reset values: data = 0, all flags and rx_busy = 0, state = IDLE, counters = 0, synchronizer flops = 1.
- Reset mid-frame: aborts the frame and drops any pending data_valid.

Input conditioning:
- rx passes through a 2-FF synchronizer, giving rx_s.
- Every bit value is the majority of 3 consecutive rx_s samples centred on mid-bit: counts MID-1, MID, MID+1, with MID = OVERSAMPLE/2 - 1 = 7.

FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY_BIT = 2) -> STOP -> IDLE.
- IDLE:
  - sample counter is held at 0;
  - a falling edge on rx_s (1 to 0) enters START, resets the counter to 0 and raises rx_busy.
- START:
  - at count MID+1, if the majority value is 1 the event is a glitch: return to IDLE with no flags;
  - otherwise, at count OVERSAMPLE-1, clear the counter and enter DATA.
- DATA:
  - bit_index runs 0..FRAME_BITS-1; each majority sample lands in shift-register position bit_index (LSB first);
  - the counter wraps at OVERSAMPLE-1, and bit_index increments on wrap;
  - after the last bit, go to PARITY or STOP.
- PARITY:
  - sample the parity bit;
  - expected value is XOR of data (even) or its inverse (odd);
  - a mismatch latches an internal parity_bad flag.
- STOP:
  - each stop bit is sampled at mid-bit; any 0 sets frame_bad;
  - at MID+1 of the final stop bit, the FSM returns to IDLE immediately, without waiting for the bit end, so it can resync on a back-to-back start bit.
- Frame complete (the cycle after the final stop sample):
  - data is loaded;
  - data_valid is set;
  - parity_err and frame_err pulse for 1 cycle per the latched flags.
  - Data is delivered even when an error is flagged.

Handshake and latency:
- data_valid clears on the cycle after data_ack = 1 while valid.
- If data_ack is high in the same cycle a new frame completes, the new byte is loaded, valid stays 1 and no overrun is flagged.
- If a frame completes while valid = 1 and ack = 0, data is overwritten with the new byte and overrun_err pulses.
- Latency: data_valid rises (2 sync + 1) cycles after the rx edge that the MID+1 stop sample sees; roughly 9.5 bit times after the start edge for 8N1.

Widths:
- Sample counter: clog2(OVERSAMPLE) bits.
- bit_index: clog2(FRAME_BITS)+1 bits.
- Comparisons are unsigned; no arithmetic overflow is possible.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state localparams (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants (PAR_EVEN = 0, PAR_ODD = 1, PAR_NONE = 2);
  - default OVERSAMPLE = 16 and a clog2 function, shared with the transmitter.
- One sub-module, uart_rx_sync:
  - 2-FF synchronizer plus a 3-tap majority shift register;
  - outputs rx_s and maj.

Test Plan:
- 8N1 frame of 0xA5, 16 clk/bit, data_ack tied high -> data = 0xA5, data_valid 1 cycle, no error flags, rx_busy low after the stop-bit sample.
- Transmitter looped to receiver (PARITY_BIT = 0), bytes 0x00, 0xFF, 0x3C sent back-to-back -> three valid events with those values in order, no errors.
- rx low pulse of 4 cycles in IDLE -> return to IDLE at count MID+1, no data_valid; a glitch of 1 cycle inside a data bit does not alter the bit (majority filter).
- Frame 0x5A with stop bit forced 0 -> data = 0x5A, frame_err pulse. Frame 0x01 with even parity bit sent as 0 -> parity_err pulse.
- Two frames (0x11, 0x22) with data_ack held low -> overrun_err pulse on the second frame, data = 0x22, valid stays 1; ack clears valid on the next cycle.
- rst_n low at bit 4 of a frame, released, then a 0x7E frame sent -> no output from the aborted frame, 0x7E received correctly.
